// File: rtl/axis_result_frame_fifo.sv
// Store-and-forward frame FIFO for the systolic array result stream.
// Whole frames (terminated by tlast) are buffered before being released
// downstream. A frame longer than the buffer falls back to cut-through
// streaming so the upstream producer can never deadlock.
module axis_result_frame_fifo #(
    parameter int C_S00_AXIS_TDATA_WIDTH = 256,
    parameter int C_S00_STRB_WIDTH       = C_S00_AXIS_TDATA_WIDTH / 8,
    parameter int DATA_WIDTH             = 9,
    parameter int FIFO_DEPTH             = 16
) (
    input  logic                                s00_axis_aclk,
    input  logic                                s00_axis_aresetn,
    input  logic                                s00_axis_tvalid,
    output logic                                s00_axis_tready,
    input  logic [C_S00_AXIS_TDATA_WIDTH-1:0]   s00_axis_tdata,
    input  logic [C_S00_STRB_WIDTH-1:0]         s00_axis_tstrb,
    input  logic                                s00_axis_tlast,
    output logic                                m00_axis_tvalid,
    input  logic                                m00_axis_tready,
    output logic [C_S00_AXIS_TDATA_WIDTH-1:0]   m00_axis_tdata,
    output logic [C_S00_STRB_WIDTH-1:0]         m00_axis_tstrb,
    output logic                                m00_axis_tlast,
    output logic [$clog2(FIFO_DEPTH):0]         occupancy,
    output logic [$clog2(FIFO_DEPTH):0]         frames_stored,
    output logic [31:0]                         frames_sent,
    output logic                                bypass_event
);

    localparam int AW      = $clog2(FIFO_DEPTH);
    localparam int CW      = AW + 1;
    localparam int EW      = C_S00_AXIS_TDATA_WIDTH + C_S00_STRB_WIDTH + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    // Reject depths the pointer arithmetic cannot handle and result elements wider than a beat.
    if ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || FIFO_DEPTH < 4 || FIFO_DEPTH > 256 ||
        DATA_WIDTH > C_S00_AXIS_TDATA_WIDTH) begin : g_bad_params
        $error("axis_result_frame_fifo: unsupported parameter combination");
    end

    typedef enum logic [1:0] {
        HOLD   = 2'd0,
        SEND   = 2'd1,
        BYPASS = 2'd2
    } state_t;

    logic [EW-1:0]  mem_q [FIFO_DEPTH];
    logic [AW-1:0]  wrPtr_q, wrPtr_d;
    logic [AW-1:0]  rdPtr_q, rdPtr_d;
    logic [CW-1:0]  occ_q, occ_d;
    logic [CW-1:0]  frames_q, frames_d;
    logic [31:0]    sent_q, sent_d;
    logic           bypass_q, bypass_d;
    state_t         state_q, state_d;

    logic [EW-1:0]  head;
    logic           headLast;
    logic           push;
    logic           pop;
    logic           outValid;

    // Head entry is presented directly (first-word-fall-through).
    assign head            = mem_q[rdPtr_q];
    assign headLast        = head[0];
    assign m00_axis_tdata  = head[EW-1 -: C_S00_AXIS_TDATA_WIDTH];
    assign m00_axis_tstrb  = head[C_S00_STRB_WIDTH:1];
    assign m00_axis_tlast  = headLast;

    assign s00_axis_tready = (occ_q != DEPTH_C);
    assign outValid        = (state_q != HOLD) && (occ_q != '0);
    assign m00_axis_tvalid = outValid;

    assign push = s00_axis_tvalid && (occ_q != DEPTH_C);
    assign pop  = outValid && m00_axis_tready;

    assign occupancy     = occ_q;
    assign frames_stored = frames_q;
    assign frames_sent   = sent_q;
    assign bypass_event  = bypass_q;

    // Beat storage; contents survive reset since only the pointers define validity.
    always_ff @(posedge s00_axis_aclk) begin
        if (push) begin
            mem_q[wrPtr_q] <= {s00_axis_tdata, s00_axis_tstrb, s00_axis_tlast};
        end
    end

    // Pointer/counter arithmetic and the HOLD/SEND/BYPASS release decision.
    always_comb begin
        wrPtr_d  = wrPtr_q;
        rdPtr_d  = rdPtr_q;
        occ_d    = occ_q + CW'(push) - CW'(pop);
        frames_d = frames_q + CW'(push && s00_axis_tlast) - CW'(pop && headLast);
        sent_d   = sent_q + 32'(pop && headLast);
        bypass_d = bypass_q;
        state_d  = state_q;

        if (push) begin
            wrPtr_d = wrPtr_q + 1'b1;
        end
        if (pop) begin
            rdPtr_d = rdPtr_q + 1'b1;
        end

        case (state_q)
            HOLD: begin
                if (frames_d != '0) begin
                    state_d = SEND;
                end else if (occ_d == DEPTH_C) begin
                    state_d  = BYPASS;
                    bypass_d = 1'b1;
                end
            end
            SEND, BYPASS: begin
                if (pop && headLast) begin
                    state_d = (frames_d != '0) ? SEND : HOLD;
                end
            end
            default: state_d = HOLD;
        endcase
    end

    // State register with asynchronous clear of all bookkeeping.
    always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
        if (!s00_axis_aresetn) begin
            wrPtr_q  <= '0;
            rdPtr_q  <= '0;
            occ_q    <= '0;
            frames_q <= '0;
            sent_q   <= '0;
            bypass_q <= 1'b0;
            state_q  <= HOLD;
        end else begin
            wrPtr_q  <= wrPtr_d;
            rdPtr_q  <= rdPtr_d;
            occ_q    <= occ_d;
            frames_q <= frames_d;
            sent_q   <= sent_d;
            bypass_q <= bypass_d;
            state_q  <= state_d;
        end
    end

endmodule

// File: tb/tb_axis_result_frame_fifo.sv
// Directed bench for axis_result_frame_fifo with a beat scoreboard.
module tb_axis_result_frame_fifo;

    localparam int W      = 256;
    localparam int S      = W / 8;
    localparam int DEPTH  = 16;
    localparam int CW     = $clog2(DEPTH) + 1;
    localparam int BEAT_W = W + S + 1;

    typedef logic [BEAT_W-1:0] beat_t;

    logic           clk;
    logic           s00_axis_aresetn;
    logic           s00_axis_tvalid;
    logic           s00_axis_tready;
    logic [W-1:0]   s00_axis_tdata;
    logic [S-1:0]   s00_axis_tstrb;
    logic           s00_axis_tlast;
    logic           m00_axis_tvalid;
    logic           m00_axis_tready;
    logic [W-1:0]   m00_axis_tdata;
    logic [S-1:0]   m00_axis_tstrb;
    logic           m00_axis_tlast;
    logic [CW-1:0]  occupancy;
    logic [CW-1:0]  frames_stored;
    logic [31:0]    frames_sent;
    logic           bypass_event;

    beat_t          sbQ[$];
    beat_t          monObs;
    beat_t          monExp;
    int             errCount;
    int             checkCount;
    logic           pushDone;

    axis_result_frame_fifo #(
        .C_S00_AXIS_TDATA_WIDTH (W),
        .C_S00_STRB_WIDTH       (S),
        .DATA_WIDTH             (9),
        .FIFO_DEPTH             (DEPTH)
    ) dut (
        .s00_axis_aclk    (clk),
        .s00_axis_aresetn (s00_axis_aresetn),
        .s00_axis_tvalid  (s00_axis_tvalid),
        .s00_axis_tready  (s00_axis_tready),
        .s00_axis_tdata   (s00_axis_tdata),
        .s00_axis_tstrb   (s00_axis_tstrb),
        .s00_axis_tlast   (s00_axis_tlast),
        .m00_axis_tvalid  (m00_axis_tvalid),
        .m00_axis_tready  (m00_axis_tready),
        .m00_axis_tdata   (m00_axis_tdata),
        .m00_axis_tstrb   (m00_axis_tstrb),
        .m00_axis_tlast   (m00_axis_tlast),
        .occupancy        (occupancy),
        .frames_stored    (frames_stored),
        .frames_sent      (frames_sent),
        .bypass_event     (bypass_event)
    );

    // Free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Bounded run time in case the design deadlocks.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog expired errors=%0d checks=%0d", errCount, checkCount);
        $fatal(1, "[TB] watchdog");
    end

    function automatic logic [S-1:0] strbOf(input logic [W-1:0] d);
        logic [S-1:0] s;
        s = ~d[S-1:0] ^ {d[7:0], d[S-1:8]};
        return s;
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checkCount++;
        assert (obs === exp) else begin
            errCount++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Every downstream handshake is compared against the oldest accepted beat.
    always @(negedge clk) begin
        if (s00_axis_aresetn && m00_axis_tvalid && m00_axis_tready) begin
            checkCount++;
            if (sbQ.size() == 0) begin
                errCount++;
                $error("[TB] FAIL out_unexpected observed data=%0h expected=no beat", m00_axis_tdata);
            end else begin
                monExp = sbQ.pop_front();
                monObs = {m00_axis_tdata, m00_axis_tstrb, m00_axis_tlast};
                assert (monObs === monExp) else begin
                    errCount++;
                    $error("[TB] FAIL out_beat observed data=%0h strb=%0h last=%0b expected data=%0h strb=%0h last=%0b",
                           monObs[BEAT_W-1 -: W], monObs[S:1], monObs[0],
                           monExp[BEAT_W-1 -: W], monExp[S:1], monExp[0]);
                end
            end
        end
    end

    task automatic applyStimulus(input logic [W-1:0] d, input logic l);
        int waitCycles;
        waitCycles      = 0;
        s00_axis_tvalid = 1'b1;
        s00_axis_tdata  = d;
        s00_axis_tstrb  = strbOf(d);
        s00_axis_tlast  = l;
        @(negedge clk);
        while (!s00_axis_tready && waitCycles < 300) begin
            @(negedge clk);
            waitCycles++;
        end
        checkOutput("push_accepted", 64'(s00_axis_tready), 64'd1);
        if (s00_axis_tready) begin
            sbQ.push_back({d, strbOf(d), l});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic stopSend();
        s00_axis_tvalid = 1'b0;
        s00_axis_tlast  = 1'b0;
    endtask

    task automatic waitDrain(input string tag);
        int n;
        n = 0;
        while ((occupancy != '0 || sbQ.size() != 0) && n < 1000) begin
            @(negedge clk);
            n++;
        end
        checkOutput({tag, "_drain_occ"}, 64'(occupancy), 64'd0);
        checkOutput({tag, "_drain_sb"}, 64'(sbQ.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic applyReset();
        s00_axis_aresetn = 1'b0;
        stopSend();
        repeat (2) @(posedge clk);
        @(negedge clk);
        s00_axis_aresetn = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        errCount         = 0;
        checkCount       = 0;
        pushDone         = 1'b0;
        s00_axis_aresetn = 1'b0;
        s00_axis_tvalid  = 1'b0;
        s00_axis_tdata   = '0;
        s00_axis_tstrb   = '0;
        s00_axis_tlast   = 1'b0;
        m00_axis_tready  = 1'b0;

        // Reset values
        applyReset();
        checkOutput("rst_s_tready", 64'(s00_axis_tready), 64'd1);
        checkOutput("rst_m_tvalid", 64'(m00_axis_tvalid), 64'd0);
        checkOutput("rst_occ", 64'(occupancy), 64'd0);
        checkOutput("rst_frames", 64'(frames_stored), 64'd0);
        checkOutput("rst_sent", 64'(frames_sent), 64'd0);
        checkOutput("rst_bypass", 64'(bypass_event), 64'd0);

        // Single 4-beat frame: nothing leaves until tlast is stored, then 1..4 back to back
        $display("[TB] single frame");
        m00_axis_tready = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            applyStimulus(W'(i), 1'b0);
            checkOutput("s1_hold_tvalid", 64'(m00_axis_tvalid), 64'd0);
        end
        applyStimulus(W'(4), 1'b1);
        stopSend();
        checkOutput("s1_release_tvalid", 64'(m00_axis_tvalid), 64'd1);
        checkOutput("s1_release_head", m00_axis_tdata[63:0], 64'd1);
        repeat (4) @(posedge clk);
        #1;
        checkOutput("s1_sent", 64'(frames_sent), 64'd1);
        checkOutput("s1_occ", 64'(occupancy), 64'd0);
        checkOutput("s1_idle_tvalid", 64'(m00_axis_tvalid), 64'd0);

        // Back-pressure: two 3-beat frames held, then released in order
        $display("[TB] back-pressure");
        m00_axis_tready = 1'b0;
        applyStimulus(W'(10), 1'b0);
        applyStimulus(W'(11), 1'b0);
        applyStimulus(W'(12), 1'b1);
        applyStimulus(W'(20), 1'b0);
        applyStimulus(W'(21), 1'b0);
        applyStimulus(W'(22), 1'b1);
        stopSend();
        checkOutput("s2_frames", 64'(frames_stored), 64'd2);
        checkOutput("s2_occ", 64'(occupancy), 64'd6);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("s2_stall_tvalid", 64'(m00_axis_tvalid), 64'd1);
        checkOutput("s2_stall_head", m00_axis_tdata[63:0], 64'd10);
        checkOutput("s2_stall_strb", 64'(m00_axis_tstrb), 64'(strbOf(W'(10))));
        m00_axis_tready = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        checkOutput("s2_sent", 64'(frames_sent), 64'd3);
        checkOutput("s2_occ_end", 64'(occupancy), 64'd0);

        // Oversized frame: fill without tlast, fall into bypass, then stream the rest
        $display("[TB] full / bypass");
        m00_axis_tready = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            applyStimulus(W'(100 + i), 1'b0);
        end
        stopSend();
        checkOutput("s3_full_tready", 64'(s00_axis_tready), 64'd0);
        checkOutput("s3_bypass", 64'(bypass_event), 64'd1);
        checkOutput("s3_occ", 64'(occupancy), 64'd16);
        checkOutput("s3_state_bypass", 64'(dut.state_q), 64'd2);
        checkOutput("s3_tvalid", 64'(m00_axis_tvalid), 64'd1);
        m00_axis_tready = 1'b1;
        for (int i = DEPTH; i < 20; i++) begin
            applyStimulus(W'(100 + i), (i == 19));
        end
        stopSend();
        waitDrain("s3");
        checkOutput("s3_sent", 64'(frames_sent), 64'd4);
        checkOutput("s3_state_hold", 64'(dut.state_q), 64'd0);
        checkOutput("s3_bypass_sticky", 64'(bypass_event), 64'd1);

        // Pointer wrap: 40 single-beat frames against a random sink
        $display("[TB] wrap");
        pushDone = 1'b0;
        fork
            begin
                for (int i = 0; i < 40; i++) begin
                    applyStimulus(W'(i), 1'b1);
                end
                stopSend();
                pushDone = 1'b1;
            end
            begin
                while (!pushDone) begin
                    @(posedge clk);
                    #1;
                    m00_axis_tready = 1'($urandom_range(0, 1));
                end
            end
        join
        m00_axis_tready = 1'b1;
        waitDrain("s4");
        checkOutput("s4_sent", 64'(frames_sent), 64'd44);
        checkOutput("s4_frames", 64'(frames_stored), 64'd0);

        // Simultaneous tlast push and tlast pop
        $display("[TB] simultaneous push/pop");
        m00_axis_tready = 1'b0;
        applyStimulus(W'(50), 1'b0);
        applyStimulus(W'(51), 1'b1);
        stopSend();
        checkOutput("s5_state_send", 64'(dut.state_q), 64'd1);
        m00_axis_tready = 1'b1;
        @(posedge clk);
        #1;
        applyStimulus(W'(60), 1'b1);
        stopSend();
        checkOutput("s5_frames", 64'(frames_stored), 64'd1);
        checkOutput("s5_occ", 64'(occupancy), 64'd1);
        checkOutput("s5_state_stay", 64'(dut.state_q), 64'd1);
        checkOutput("s5_sent_mid", 64'(frames_sent), 64'd45);
        waitDrain("s5");
        checkOutput("s5_sent", 64'(frames_sent), 64'd46);

        // Reset in the middle of a frame, then a clean frame afterwards
        $display("[TB] mid-operation reset");
        m00_axis_tready = 1'b1;
        applyStimulus(W'(70), 1'b0);
        applyStimulus(W'(71), 1'b0);
        stopSend();
        s00_axis_aresetn = 1'b0;
        #1;
        checkOutput("s6_occ", 64'(occupancy), 64'd0);
        checkOutput("s6_frames", 64'(frames_stored), 64'd0);
        checkOutput("s6_sent", 64'(frames_sent), 64'd0);
        checkOutput("s6_bypass", 64'(bypass_event), 64'd0);
        checkOutput("s6_tvalid", 64'(m00_axis_tvalid), 64'd0);
        sbQ.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        s00_axis_aresetn = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("s6_post_tready", 64'(s00_axis_tready), 64'd1);
        for (int i = 80; i <= 83; i++) begin
            applyStimulus(W'(i), (i == 83));
        end
        stopSend();
        waitDrain("s6");
        checkOutput("s6_post_sent", 64'(frames_sent), 64'd1);
        checkOutput("s6_post_state", 64'(dut.state_q), 64'd0);

        $display("Result: errors=%0d of %0d checks", errCount, checkCount);
        $finish;
    end

endmodule
